// File: rtl/butterfly_pkg.sv
// Shared ButterFly execute-stage types for the M-extension unit.
// funct3-encoded multiply/divide operations.
package butterfly_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  function automatic logic is_div_op(muldiv_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply bit or
// restoring-divide bit on the {hi,lo} accumulator pair.
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, m};
    hi_o = '0;
    lo_o = '0;
    if (is_div) begin
      // remainder < divisor, so a non-negative diff fits XLEN
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_o = sh[XLEN-1:0];
        lo_o = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Define BUTTERFLY_MULDIV_FASTMUL_EN for a single-cycle multiplier.
module muldiv_iter_unit
  import butterfly_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  muldiv_op_e      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int N  = XLEN / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE
  } state_e;

  state_e          state;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] opa_q, opb_q, m_q, hi_q, lo_q, result_q;
  logic            sa_q, sb_q, valid_q;
  logic [CW-1:0]   cnt_q;

  logic            a_sgn, b_sgn, b_zero, ovf, spec_hit;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, quot, rmd, fix_res;

  logic [XLEN-1:0] hi_c [STEPS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [STEPS_PER_CYCLE+1];

  function automatic logic [XLEN-1:0] mul_sel(
    muldiv_op_e op, logic [2*XLEN-1:0] p, logic neg);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (op == MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    a_sgn    = (op_q inside {MULH, MULHSU, DIV, REM}) & opa_q[XLEN-1];
    b_sgn    = (op_q inside {MULH, DIV, REM}) & opb_q[XLEN-1];
    a_mag    = a_sgn ? -opa_q : opa_q;
    b_mag    = b_sgn ? -opb_q : opb_q;
    b_zero   = (opb_q == '0);
    ovf      = (op_q inside {DIV, REM}) && (opa_q == MIN) && (opb_q == '1);
    spec_hit = is_div_op(op_q) && (b_zero || ovf);
    spec_res = '0;
    if (b_zero)
      spec_res = (op_q inside {REM, REMU}) ? opa_q : '1;
    else
      spec_res = (op_q inside {REM, REMU}) ? '0 : MIN;
    quot    = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rmd     = sa_q ? -hi_q : hi_q;
    fix_res = is_div_op(op_q)
            ? ((op_q inside {REM, REMU}) ? rmd : quot)
            : mul_sel(op_q, {hi_q, lo_q}, sa_q ^ sb_q);
  end

`ifdef BUTTERFLY_MULDIV_FASTMUL_EN
  logic [2*XLEN-1:0] fprod;
  assign fprod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .is_div (is_div_op(op_q)),
      .hi     (hi_c[g]),
      .lo     (lo_c[g]),
      .m      (m_q),
      .hi_o   (hi_c[g+1]),
      .lo_o   (lo_c[g+1])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      op_q     <= MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_i) begin
            op_q  <= op_i;
            opa_q <= operand_a_i;
            opb_q <= operand_b_i;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          sa_q  <= a_sgn;
          sb_q  <= b_sgn;
          cnt_q <= '0;
          if (spec_hit) begin
            result_q <= spec_res;
            valid_q  <= 1'b1;
            state    <= S_DONE;
          end
`ifdef BUTTERFLY_MULDIV_FASTMUL_EN
          else if (!is_div_op(op_q)) begin
            result_q <= mul_sel(op_q, fprod, a_sgn ^ b_sgn);
            valid_q  <= 1'b1;
            state    <= S_DONE;
          end
`endif
          else begin
            m_q   <= is_div_op(op_q) ? b_mag : a_mag;
            lo_q  <= is_div_op(op_q) ? a_mag : b_mag;
            hi_q  <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          hi_q  <= hi_c[STEPS_PER_CYCLE];
          lo_q  <= lo_c[STEPS_PER_CYCLE];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (state == S_IDLE);
  assign busy_o   = (state != S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (XLEN 32, 1 and 4 steps/cycle).
// Latency counts the accepting edge as cycle 1.
module tb_muldiv_iter_unit;
  import butterfly_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
  muldiv_op_e  op_i = MUL;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;

  logic        v4 = 1'b0;
  muldiv_op_e  op4 = MUL;
  logic [31:0] a4 = '0, b4 = '0;
  logic        rdy4, vo4, busy4;
  logic [31:0] res4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .operand_a_i(a_i), .operand_b_i(b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .busy_o(busy_o)
  );

  muldiv_iter_unit #(.XLEN(32), .STEPS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v4), .ready_o(rdy4),
    .op_i(op4), .operand_a_i(a4), .operand_b_i(b4), .flush_i(1'b0),
    .valid_o(vo4), .ready_i(1'b1), .result_o(res4), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input muldiv_op_e op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    logic rdy_bad;
    logic [31:0] r0;
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    chk({tag, "_rdy_pre"}, 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0; a_i = '1; b_i = '1;
    lat = 1; rdy_bad = 1'b0;
    do begin
      if (ready_o) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end while (!valid_o && lat < 200);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result_o), 64'(exp));
    chk({tag, "_rdy_low"}, 64'(rdy_bad), 64'd0);
    r0 = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, 64'(valid_o), 64'd1);
      chk({tag, "_hold_r"}, 64'(result_o), 64'(r0));
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'({valid_o, ready_o, result_o}),
        64'({1'b0, 1'b1, exp}));
  endtask

  initial begin
    int lat;
    logic vseen;
    #12;
    chk("rst_out", 64'({ready_o, valid_o, busy_o, result_o}),
        64'({1'b1, 1'b0, 1'b0, 32'h0}));
    rst_n = 1'b1;

    run_op("mul",    MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, 0);
    run_op("mulh",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35, 0);
    run_op("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 0);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 0);
    run_op("div",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 0);
    run_op("rem",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 0);
    run_op("divu",   DIVU,   32'd100,      32'd7,        32'd14,       35, 0);
    run_op("remu",   REMU,   32'd100,      32'd7,        32'd2,        35, 10);
    run_op("div0",   DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2,  0);
    run_op("rem0",   REM,    32'd5,        32'd0,        32'd5,        2,  0);
    run_op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  0);
    run_op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  0);
`ifdef BUTTERFLY_MULDIV_FASTMUL_EN
    run_op("fmul",   MUL,    32'd12,       32'd12,       32'd144,      2,  0);
`else
    run_op("fmul",   MUL,    32'd12,       32'd12,       32'd144,      35, 0);
`endif

    // flush on CALC cycle 10
    @(negedge clk);
    valid_i = 1'b1; op_i = DIVU; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    vseen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (valid_o) vseen = 1'b1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_st", 64'({ready_o, busy_o, valid_o}), 64'({1'b1, 1'b0, 1'b0}));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) vseen = 1'b1;
    end
    chk("flush_noval", 64'(vseen), 64'd0);

    // flush beats a same-cycle request
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = DIVU; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_req", 64'({ready_o, busy_o}), 64'({1'b1, 1'b0}));

    // STEPS_PER_CYCLE = 4 instance
    @(negedge clk);
    v4 = 1'b1; op4 = DIVU; a4 = 32'hFFFFFFFF; b4 = 32'd3;
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!vo4 && lat < 200);
    chk("s4_lat", 64'(lat), 64'd11);
    chk("s4_res", 64'(res4), 64'h55555555);

    // async reset mid-CALC
    @(negedge clk);
    valid_i = 1'b1; op_i = MULHU; a_i = 32'h1234; b_i = 32'h5678;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({ready_o, valid_o, busy_o, result_o}),
        64'({1'b1, 1'b0, 1'b0, 32'h0}));
    chk("rst_mid4", 64'({rdy4, vo4, busy4, res4}),
        64'({1'b1, 1'b0, 1'b0, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", DIVU, 32'd100, 32'd7, 32'd14, 35, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
# muldiv_iter_unit

Parametrised iterative RV32M/RV64M multiply/divide unit for the ButterFly execute stage. It implements all eight M-extension operations with a valid/ready handshake on both sides, a flush input, and RISC-V-compliant corner-case results. Each iteration retires a configurable number of bits, so designers can trade latency against area. It replaces the fixed-latency muldiv unit in the EX stage; the hazard unit stalls on `ready_o`/`valid_o`.

## Interface
- `XLEN`, 32, operand/result width (32 or 64)
- `STEPS_PER_CYCLE`, 1, bits retired per CALC cycle; 1, 2 or 4; must divide XLEN
- `clk_i` in 1 clock
- `rst_n_i` in 1 reset, asynchronous, active-low
- `valid_i` in 1 request valid
- `ready_o` out 1 unit can accept a request
- `op_i` in 3 operation, `muldiv_op_e`
- `operand_a_i` in XLEN rs1 value
- `operand_b_i` in XLEN rs2 value
- `flush_i` in 1 abort the current operation
- `valid_o` out 1 result valid
- `ready_i` in 1 consumer accepts the result
- `result_o` out XLEN result
- `busy_o` out 1 state ≠ IDLE

## Operation
- States:
  - IDLE → PREP on `valid_i && ready_o`.
  - PREP → CALC normally. PREP → DONE for special cases, and for MUL* when the fast multiplier is compiled in.
  - CALC → FIXUP after N = XLEN/STEPS_PER_CYCLE cycles.
  - FIXUP → DONE.
  - DONE → IDLE on `ready_i`.
- Request capture:
  - `ready_o` = (state == IDLE).
  - `op_i` and the operands are registered on accept. Inputs are don't-care afterwards.
- PREP:
  - Records operand signs: MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; other ops are unsigned.
  - Converts signed operands to magnitudes.
  - Detects special cases.
- CALC, multiply: shift-add on magnitudes into a 2·XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per step.
- FIXUP:
  - Product is negated if the operand signs differ.
  - Quotient sign = sa ^ sb. Remainder sign = sa.
- Result selection:
  - MUL returns the low half of the product. MULH/MULHSU/MULHU return the high half.
  - DIV/DIVU return the quotient. REM/REMU return the remainder.
- Special cases (bypass CALC):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = MIN, b = −1): DIV → MIN; REM → 0.
- Flush:
  - `flush_i` in any state → IDLE on the next edge, with `valid_o` = 0 and no result.
  - Flush wins over a same-cycle `valid_i`; that request is not accepted.
- Back-to-back requests: no overlap. The DONE handshake cycle returns to IDLE, and the next accept can occur one cycle later.

## Timing
- Reset values:
  - state IDLE.
  - `ready_o` = 1, `valid_o` = 0, `busy_o` = 0.
  - `result_o` = 0.
  - All internal accumulators = 0.
- Latency, counted from the accepting edge to the first cycle with `valid_o` high:
  - Normal: N + 3 (35 for XLEN = 32, STEPS_PER_CYCLE = 1).
  - Special case: 2.
- While `valid_o` is high and `ready_i` is low, `result_o` and `valid_o` hold stable.
- `result_o` is registered and holds its last value in IDLE.
- An asynchronous reset mid-operation discards all state. There is no partial output.

## Configuration
- `BUTTERFLY_MULDIV_FASTMUL_EN`
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2·XLEN multiplier in PREP and go straight to DONE, giving latency 2. Division is unchanged.
  - Undefined: all multiplies use the iterative path, with latency N + 3. No hardware multiplier is inferred.

## Structure
- `butterfly_pkg` holds:
  - `muldiv_op_e`, using the funct3 encoding: MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3, DIV = 4, DIVU = 5, REM = 6, REMU = 7.
  - Helper `is_div_op()`.
- The state enum is local to the module.
- Sub-module `muldiv_iter_step`: combinational single-bit shift-add / restore-subtract step, instantiated STEPS_PER_CYCLE times in a chain.

## Test plan
All cases use XLEN = 32, STEPS_PER_CYCLE = 1, macro off unless stated.
1. MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with `valid_o` exactly 35 cycles after accept and `ready_o` low throughout.
2. High halves:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. Division:
   - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
   - DIVU 100 / 7 → 14; REMU → 2.
4. Special cases:
   - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
   - Each at latency 2.
5. Backpressure and flush:
   - Hold `ready_i` = 0 for 10 cycles → `result_o` and `valid_o` stable.
   - Separate op: `flush_i` on CALC cycle 10 → next cycle `ready_o` = 1, `busy_o` = 0, and `valid_o` never asserted.
   - `flush_i` with `valid_i` in IDLE → not accepted.
6. Configuration variants:
   - STEPS_PER_CYCLE = 4: DIVU 0xFFFFFFFF / 3 → 0x55555555 at latency 11.
   - Macro defined: MUL 12 × 12 → 144 at latency 2.
   - Reset asserted mid-CALC → all outputs return to reset values immediately.
